i2c_adc_target: RTL and testbench

- I2C target (slave) emulating an MCP3221-style 12-bit ADC on the bus.
- Responds to reads from our I2C master: ACKs its address and returns {4'b0000, data[11:8]} then data[7:0].
- While the master ACKs, it keeps streaming conversion pairs; a NACK ends the transfer.
- Used on-FPGA as a loopback target for master bring-up and as a synthesizable bench model. Samples come from a local sample source, standing in for the HPS-side test pattern.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/i2c_adc_target.sv | 181 ++++++++++++++++++
 tb/tb_i2c_adc_target.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C ADC target.
// The state enum and address constants are also intended for a future master-side block.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        TX_UPPER,
        TX_LOWER,
        MACK_UPPER,
        MACK_LOWER,
        WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic [6:0] MCP3221_ADDR = 7'b1001101;
    localparam logic       I2C_RW_READ  = 1'b1;

    // The first byte of a conversion pair carries the upper nibble behind four zeros.
    function automatic logic [7:0] upper_byte(input logic [11:0] value);
        return {4'b0000, value[11:8]};
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus edge and bus-condition (START/STOP) pulse generation.
// Every output pulse lasts exactly one clk cycle.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    // Preset to 1 so that leaving reset looks like an idle bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_adc_target.sv
// I2C read-only target that mimics an MCP3221 12-bit ADC: it ACKs its address and
// streams {4'b0, data[11:8]}, data[7:0] pairs for as long as the master keeps ACKing.
module i2c_adc_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = MCP3221_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    output logic        busy,
    output logic        pair_done,
    output logic        rd_nack
);

    i2c_tgt_state_t state;
    i2c_tgt_state_t state_next;

    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic        bus_event;
    logic [2:0]  bit_cnt;
    logic        last_bit;
    logic [6:0]  addr_shift;
    logic        addr_hit;
    logic [11:0] shadow;
    logic [11:0] tx;
    logic [11:0] snap_val;
    logic [7:0]  cur_byte;

    logic addr_shift_en, addr_accept, ack_drive, load_upper, load_lower, bit_step;
    logic pair_pulse, nack_pulse;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_s    (scl_s),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign bus_event = start_det | stop_det;
    assign last_bit  = (bit_cnt == 3'd7);
    assign addr_hit  = (addr_shift == DEV_ADDR);
    // A sample arriving on the snapshot cycle bypasses the shadow register.
    assign snap_val  = sample_valid ? sample_data : shadow;
    assign cur_byte  = (state == TX_LOWER) ? tx[7:0] : upper_byte(tx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && last_bit) begin
                        state_next = (addr_hit && sda_s == I2C_RW_READ) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK:   if (scl_fall && sda_oe) state_next = TX_UPPER;
                TX_UPPER:   if (scl_fall && last_bit) state_next = MACK_UPPER;
                TX_LOWER:   if (scl_fall && last_bit) state_next = MACK_LOWER;
                MACK_UPPER: begin
                    if (scl_rise && sda_s)  state_next = WAIT_STOP;
                    else if (scl_fall)      state_next = TX_LOWER;
                end
                MACK_LOWER: begin
                    if (scl_rise && sda_s)  state_next = WAIT_STOP;
                    else if (scl_fall)      state_next = TX_UPPER;
                end
                default: ;
            endcase
        end
    end

    // The acknowledge is sampled on the rising edge; the next byte starts on the following fall.
    always_comb begin
        addr_shift_en = 1'b0;
        addr_accept   = 1'b0;
        ack_drive     = 1'b0;
        load_upper    = 1'b0;
        load_lower    = 1'b0;
        bit_step      = 1'b0;
        pair_pulse    = 1'b0;
        nack_pulse    = 1'b0;
        if (!bus_event) begin
            case (state)
                ADDR: begin
                    addr_shift_en = scl_rise;
                    addr_accept   = scl_rise && last_bit && addr_hit && (sda_s == I2C_RW_READ);
                end
                ADDR_ACK: begin
                    ack_drive  = scl_fall && !sda_oe;
                    load_upper = scl_fall &&  sda_oe;
                end
                TX_UPPER, TX_LOWER: bit_step = scl_fall;
                MACK_UPPER: load_lower = scl_fall;
                MACK_LOWER: begin
                    pair_pulse = scl_rise;
                    nack_pulse = scl_rise && sda_s;
                    load_upper = scl_fall;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            pair_done  <= 1'b0;
            rd_nack    <= 1'b0;
            bit_cnt    <= '0;
            addr_shift <= '0;
            shadow     <= '0;
            tx         <= '0;
        end else begin
            pair_done <= pair_pulse;
            rd_nack   <= nack_pulse;
            if (sample_valid) begin
                shadow <= sample_data;
            end
            if (bus_event) begin
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                if (addr_shift_en) begin
                    addr_shift <= {addr_shift[5:0], sda_s};
                    bit_cnt    <= bit_cnt + 3'd1;
                end
                if (addr_accept) begin
                    busy <= 1'b1;
                end
                if (ack_drive) begin
                    sda_oe <= 1'b1;
                end
                // The upper byte always opens with a padding zero, so SDA is pulled low.
                if (load_upper) begin
                    tx      <= snap_val;
                    sda_oe  <= 1'b1;
                    bit_cnt <= '0;
                end
                if (load_lower) begin
                    sda_oe  <= ~tx[7];
                    bit_cnt <= '0;
                end
                if (bit_step) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    sda_oe  <= last_bit ? 1'b0 : ~cur_byte[3'd6 - bit_cnt];
                end
                if (state == WAIT_STOP) begin
                    sda_oe <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: bit-banged I2C master, table of read transactions,
// expected bytes queued when samples are driven and compared as the master reads them.
module tb_i2c_adc_target;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        ov = 1'b0;
    logic        sda_in;
    logic        sda_oe;
    logic [11:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        busy, pair_done, rd_nack;

    int checks = 0;
    int errors = 0;
    int pd_cnt = 0;
    int rn_cnt = 0;
    int viol = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic oe_last = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [11:0] sample;
        logic [7:0]  addr_rw;
        int          npairs;
        logic        ack;
    } vec_t;
    vec_t vecs[7];

    // Wired-AND bus; in override mode the master alone owns SDA.
    assign sda_in = ov ? m_sda : (m_sda & ~sda_oe);

    always #5 clk = ~clk;

    i2c_adc_target #(
        .DEV_ADDR   (7'b1001101),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scl_in      (scl),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .busy        (busy),
        .pair_done   (pair_done),
        .rd_nack     (rd_nack)
    );

    always @(negedge clk) begin
        if (pair_done) pd_cnt++;
        if (rd_nack) rn_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (reset_n && !ov && scl && (sda_oe != oe_last)) viol++;
        oe_last = sda_oe;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [7:0] got);
        logic [7:0] want;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            want = exp_q.pop_front();
            check(name, got, want);
        end
    endtask

    task automatic push_pair(input logic [11:0] s);
        exp_q.push_back({4'h0, s[11:8]});
        exp_q.push_back(s[7:0]);
    endtask

    task automatic drive_sample(input logic [11:0] v);
        @(negedge clk);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
        #Q;
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; #Q;
        scl = 1'b1; #Q;
        #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        b = sda_in;   #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic put_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
    endtask

    task automatic get_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
    endtask

    task automatic clear_mon();
        pd_cnt = 0;
        rn_cnt = 0;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic run_read(input string tag, input logic [7:0] addr_rw, input int npairs,
                            input logic exp_ack);
        logic       b;
        logic [7:0] got;
        clear_mon();
        i2c_start();
        put_byte(addr_rw);
        get_bit(b);
        check({tag, "_addr_ack"}, b, exp_ack ? 32'd0 : 32'd1);
        if (exp_ack) begin
            check({tag, "_busy_on"}, busy, 32'd1);
            for (int p = 0; p < npairs; p++) begin
                get_byte(got);
                pop_cmp($sformatf("%s_p%0d_upper", tag, p), got);
                put_bit(1'b0);
                get_byte(got);
                pop_cmp($sformatf("%s_p%0d_lower", tag, p), got);
                put_bit(p == npairs - 1);
            end
        end
        i2c_stop();
        repeat (4) @(negedge clk);
        check({tag, "_busy_off"}, busy, 32'd0);
        check({tag, "_pair_done_cnt"}, pd_cnt, exp_ack ? npairs : 0);
        check({tag, "_rd_nack_cnt"}, rn_cnt, (exp_ack && npairs > 0) ? 32'd1 : 32'd0);
        if (!exp_ack) begin
            check({tag, "_no_drive"}, oe_seen, 32'd0);
            check({tag, "_no_busy"}, busy_seen, 32'd0);
        end
    endtask

    initial begin
        logic       b;
        logic [2:0] bits3;
        logic [7:0] got;

        vecs[0] = '{12'hABC, 8'h9B, 1, 1'b1};
        vecs[1] = '{12'h456, 8'h99, 0, 1'b0};
        vecs[2] = '{12'h789, 8'h9A, 0, 1'b0};
        vecs[3] = '{12'h000, 8'h9B, 1, 1'b1};
        vecs[4] = '{12'hFFF, 8'h9B, 2, 1'b1};
        vecs[5] = '{12'h7E5, 8'h1B, 0, 1'b0};
        vecs[6] = '{12'h5C3, 8'h9B, 1, 1'b1};

        #12;
        check("reset_sda_oe", sda_oe, 32'd0);
        check("reset_busy", busy, 32'd0);
        check("reset_pair_done", pair_done, 32'd0);
        check("reset_rd_nack", rd_nack, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive_sample(vecs[i].sample);
            if (vecs[i].ack) begin
                for (int p = 0; p < vecs[i].npairs; p++) push_pair(vecs[i].sample);
            end
            run_read($sformatf("v%0d", i), vecs[i].addr_rw, vecs[i].npairs, vecs[i].ack);
        end

        // Streaming: a new sample lands while pair 2's upper byte is on the bus.
        drive_sample(12'h123);
        push_pair(12'h123);
        push_pair(12'h123);
        clear_mon();
        i2c_start();
        put_byte(8'h9B);
        get_bit(b);
        check("stream_addr_ack", b, 32'd0);
        get_byte(got); pop_cmp("stream_p1_upper", got); put_bit(1'b0);
        get_byte(got); pop_cmp("stream_p1_lower", got); put_bit(1'b0);
        fork
            get_byte(got);
            begin
                #(4 * Q * 3);
                drive_sample(12'hFFF);
                push_pair(12'hFFF);
            end
        join
        pop_cmp("stream_p2_upper", got); put_bit(1'b0);
        get_byte(got); pop_cmp("stream_p2_lower", got); put_bit(1'b0);
        get_byte(got); pop_cmp("stream_p3_upper", got); put_bit(1'b0);
        get_byte(got); pop_cmp("stream_p3_lower", got); put_bit(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("stream_pair_done_cnt", pd_cnt, 32'd3);
        check("stream_rd_nack_cnt", rn_cnt, 32'd1);
        check("stream_busy_off", busy, 32'd0);

        // Repeated START forced in the middle of the lower byte while the target pulls SDA low.
        drive_sample(12'h5A5);
        exp_q.push_back(8'h05);
        clear_mon();
        i2c_start();
        put_byte(8'h9B);
        get_bit(b);
        check("rs_addr_ack", b, 32'd0);
        get_byte(got); pop_cmp("rs_upper", got); put_bit(1'b0);
        for (int i = 2; i >= 0; i--) begin
            get_bit(b);
            bits3[i] = b;
        end
        check("rs_lower_3bits", bits3, 32'h5);
        check("rs_pre_oe", sda_oe, 32'd1);
        ov = 1'b1;
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0;
        for (int i = 0; i < 8 && sda_oe; i++) @(negedge clk);
        check("rs_oe_release", sda_oe, 32'd0);
        check("rs_busy_clear", busy, 32'd0);
        #Q;
        scl = 1'b0; #Q;
        ov = 1'b0;
        push_pair(12'h5A5);
        put_byte(8'h9B);
        get_bit(b);
        check("rs_readdr_ack", b, 32'd0);
        get_byte(got); pop_cmp("rs2_upper", got); put_bit(1'b0);
        get_byte(got); pop_cmp("rs2_lower", got); put_bit(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("rs_pair_done_cnt", pd_cnt, 32'd1);
        check("rs_rd_nack_cnt", rn_cnt, 32'd1);

        // Asynchronous reset while the target drives a zero in the upper byte.
        drive_sample(12'h3C7);
        i2c_start();
        put_byte(8'h9B);
        get_bit(b);
        check("rst_addr_ack", b, 32'd0);
        get_bit(b);
        get_bit(b);
        check("rst_pre_oe", sda_oe, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_oe", sda_oe, 32'd0);
        check("rst_async_busy", busy, 32'd0);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        push_pair(12'h000);
        run_read("post_rst", 8'h9B, 1, 1'b1);

        check("queue_drained", exp_q.size(), 32'd0);
        check("sda_change_while_scl_high", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
